// File: rtl/serial_operand_serializer_if.sv
// serial_operand_serializer_if: parallel word-pair handshake in, LSB-first serial bit pairs out.
interface serial_operand_serializer_if #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH)
);
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [LW-1:0]    in_len;
    logic             en;
    logic             vld;
    logic             a;
    logic             b;
    logic             last;
    logic             busy;

    modport master (
        output in_vld, in_a, in_b, in_len, en,
        input  in_rdy, vld, a, b, last, busy
    );

    modport slave (
        input  in_vld, in_a, in_b, in_len, en,
        output in_rdy, vld, a, b, last, busy
    );
endinterface

// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer: shifts a captured operand pair out LSB-first, one pair per enabled cycle.
module serial_operand_serializer #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH)
) (
    input logic                     clk,
    input logic                     rst,
    serial_operand_serializer_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [LW-1:0]    cnt_q, cnt_d, len_q, len_d;
    logic             done, advance, xfer;

    assign done    = cnt_q == len_q;
    assign advance = state_q == SHIFT && bus.en;
    assign xfer    = bus.in_vld && bus.in_rdy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // A finishing word and a new transfer share one edge, so back-to-back words leave no gap.
    always_comb begin
        state_d = xfer ? SHIFT : (advance && done) ? IDLE : state_q;
        sh_a_d  = xfer ? bus.in_a : (advance && !done) ? {1'b0, sh_a_q[WIDTH-1:1]} : sh_a_q;
        sh_b_d  = xfer ? bus.in_b : (advance && !done) ? {1'b0, sh_b_q[WIDTH-1:1]} : sh_b_q;
        cnt_d   = xfer ? '0 : (advance && !done) ? cnt_q + LW'(1) : cnt_q;
        len_d   = xfer ? bus.in_len : len_q;
    end

    always_comb begin
        bus.in_rdy = state_q == IDLE || (advance && done);
        bus.vld    = advance;
        bus.a      = advance ? sh_a_q[0] : 1'b0;
        bus.b      = advance ? sh_b_q[0] : 1'b0;
        bus.last   = advance && done;
        bus.busy   = state_q == SHIFT;
    end
endmodule

// File: tb/tb_serial_operand_serializer.sv
// tb_serial_operand_serializer: table vectors, corner sequences and random traffic against a word/bit-index model.
module tb_serial_operand_serializer;
    typedef struct {
        logic       rst, iv;
        logic [7:0] ia, ib;
        logic [2:0] il;
        logic       en;
        logic       vld, a, b, last, busy, rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    serial_operand_serializer_if #(.WIDTH(8)) bus ();
    serial_operand_serializer #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    bit         m_act = 1'b0;
    logic [7:0] m_wa, m_wb;
    int         m_len, m_pos;
    logic       obs_vld, obs_a, obs_last;
    vec_t       tbl[13];
    vec_t       none;

    function automatic vec_t mk(logic r, logic iv, logic [7:0] ia, logic [7:0] ib, logic [2:0] il, logic e,
                                logic v, logic oa, logic ob, logic l, logic bz, logic rd);
        vec_t t;
        t.rst = r; t.iv = iv; t.ia = ia; t.ib = ib; t.il = il; t.en = e;
        t.vld = v; t.a = oa; t.b = ob; t.last = l; t.busy = bz; t.rdy = rd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // mode 0: drive only, 1: compare with model, 2: also compare with the table row t
    task automatic step(input vec_t v, input int mode, input vec_t t);
        logic e_vld, e_a, e_b, e_last, e_rdy;
        rst = v.rst; bus.in_vld = v.iv; bus.in_a = v.ia; bus.in_b = v.ib; bus.in_len = v.il; bus.en = v.en;
        e_vld  = m_act && v.en;
        e_a    = e_vld ? m_wa[m_pos] : 1'b0;
        e_b    = e_vld ? m_wb[m_pos] : 1'b0;
        e_last = e_vld && m_pos == m_len;
        e_rdy  = !m_act || (v.en && m_pos == m_len);
        @(negedge clk);
        obs_vld = bus.vld; obs_a = bus.a; obs_last = bus.last;
        if (mode >= 1) begin
            chk("model_vld", bus.vld, e_vld);
            chk("model_a", bus.a, e_a);
            chk("model_b", bus.b, e_b);
            chk("model_last", bus.last, e_last);
            chk("model_busy", bus.busy, m_act);
            chk("model_rdy", bus.in_rdy, e_rdy);
        end
        if (mode == 2) begin
            chk("tbl_vld", bus.vld, t.vld);
            chk("tbl_a", bus.a, t.a);
            chk("tbl_b", bus.b, t.b);
            chk("tbl_last", bus.last, t.last);
            chk("tbl_busy", bus.busy, t.busy);
            chk("tbl_rdy", bus.in_rdy, t.rdy);
        end
        @(posedge clk);
        if (!v.rst) m_act = 1'b0;
        else if (v.iv && e_rdy) begin
            m_act = 1'b1; m_wa = v.ia; m_wb = v.ib; m_len = int'(v.il); m_pos = 0;
        end else if (m_act && v.en) begin
            if (m_pos == m_len) m_act = 1'b0;
            else m_pos++;
        end
        #1;
    endtask

    task automatic go(input logic iv, input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] il, input logic e);
        step(mk(1'b1, iv, ia, ib, il, e, 0, 0, 0, 0, 0, 0), 1, none);
    endtask

    initial begin
        logic [7:0] ea, eb, got;
        int n, lasts;
        bit fin;
        ea = 8'h5A; eb = 8'h3C;
        tbl[0] = mk(1, 1, 8'h5A, 8'h3C, 3'd7, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            tbl[1+i] = mk(1, 0, 8'h00, 8'h00, 3'd0, 1, 1, ea[i], eb[i], i == 7, 1, i == 7);
        tbl[9]  = mk(1, 0, 8'h00, 8'h00, 3'd0, 1, 0, 0, 0, 0, 0, 1);
        tbl[10] = mk(1, 1, 8'h01, 8'h01, 3'd0, 1, 0, 0, 0, 0, 0, 1);
        tbl[11] = mk(1, 0, 8'h00, 8'h00, 3'd0, 1, 1, 1, 1, 1, 1, 1);
        tbl[12] = mk(1, 0, 8'h00, 8'h00, 3'd0, 1, 0, 0, 0, 0, 0, 1);
        none = tbl[12];

        #1;
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0, none);
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0, none);
        for (int i = 0; i < 13; i++) step(tbl[i], 2, tbl[i]);

        // back-to-back: in_vld held across both words
        go(1, 8'hFF, 8'h01, 3'd7, 1);
        for (int i = 0; i < 8; i++) go(1, (i == 7) ? 8'h0F : 8'hFF, (i == 7) ? 8'hF0 : 8'h01, (i == 7) ? 3'd3 : 3'd7, 1);
        for (int i = 0; i < 5; i++) go(0, 8'h00, 8'h00, 3'd0, 1);

        // bubbles: en pattern 1,0,0,1,...
        go(1, 8'hA5, 8'h00, 3'd7, 1);
        got = '0; n = 0; lasts = 0; fin = 0;
        for (int k = 0; k < 40 && !fin; k++) begin
            go(0, 8'h00, 8'h00, 3'd0, (k % 4 == 0) || (k % 4 == 3));
            if (obs_vld) begin
                if (n < 8) got[n] = obs_a;
                n++;
                if (obs_last) begin lasts++; fin = 1; end
            end
        end
        chk("bubble_done", fin, 1'b1);
        checks++;
        if (got !== 8'hA5 || n != 8 || lasts != 1) begin
            errors++;
            $display("FAIL bubble_seq: got a=%h n=%0d lasts=%0d expected a=a5 n=8 lasts=1", got, n, lasts);
        end

        // busy rejection: second word offered from cnt=0 onward
        go(1, 8'hC3, 8'h3C, 3'd7, 1);
        for (int i = 0; i < 9; i++) begin
            step(mk(1, 1, 8'h33, 8'hCC, 3'd2, 1, 0, 0, 0, 0, 0, 0), 1, none);
            if (i == 2) chk("busy_rdy_cnt2", bus.in_rdy, 1'b0);
        end
        for (int i = 0; i < 4; i++) go(0, 8'h00, 8'h00, 3'd0, 1);

        // reset mid-word at cnt=3
        go(1, 8'hE7, 8'h18, 3'd7, 1);
        for (int i = 0; i < 3; i++) go(0, 8'h00, 8'h00, 3'd0, 1);
        step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1, none);
        step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), 2, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        go(1, 8'h96, 8'h69, 3'd7, 1);
        for (int i = 0; i < 9; i++) go(0, 8'h00, 8'h00, 3'd0, 1);

        // random traffic
        for (int i = 0; i < 600; i++)
            step(mk(($urandom_range(0, 49) != 0), $urandom_range(0, 1), 8'($urandom), 8'($urandom),
                    3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), 0, 0, 0, 0, 0, 0), 1, none);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
